// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; results go straight to the register-file write port.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [AW-1:0]    rd_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

  state_t           state_r;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] result_r;
  logic [AW-1:0]    rd_out_r, rd_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r, div_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r, neg_r_r, sel_rem_r;

  logic             signed_op_s, a_neg_s, b_neg_s, div_zero_s, overflow_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, special_s;
  logic [WIDTH:0]   shift_s, rem_next_s;
  logic             ge_s;
  logic [WIDTH-1:0] quo_next_s, q_fix_s, r_fix_s;
  logic             unused_s;

  // Operand decode at the accept edge: magnitudes, signs and RISC-V special results.
  always_comb begin
    signed_op_s = ~op[0];
    a_neg_s     = signed_op_s & a[WIDTH-1];
    b_neg_s     = signed_op_s & b[WIDTH-1];
    a_mag_s     = a_neg_s ? (~a + ONE) : a;
    b_mag_s     = b_neg_s ? (~b + ONE) : b;
    div_zero_s  = (b == ZERO);
    overflow_s  = signed_op_s & (a == MIN) & (b == ONES);
    if (div_zero_s) begin
      special_s = op[1] ? a : ONES;
    end else begin
      special_s = op[1] ? ZERO : MIN;
    end
  end

  // One restoring step plus the sign fix-up applied when the last step lands.
  always_comb begin
    shift_s    = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    ge_s       = (shift_s >= {1'b0, div_r});
    rem_next_s = ge_s ? (shift_s - {1'b0, div_r}) : shift_s;
    quo_next_s = {quo_r[WIDTH-2:0], ge_s};
    q_fix_s    = neg_q_r ? (~quo_next_s + ONE) : quo_next_s;
    r_fix_s    = neg_r_r ? (~rem_next_s[WIDTH-1:0] + ONE) : rem_next_s[WIDTH-1:0];
    // the remainder never exceeds the divisor, so the top rem bit is only a carry
    unused_s   = rem_r[WIDTH] ^ rem_next_s[WIDTH];
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= ZERO;
      rd_out_r  <= {AW{1'b0}};
      rd_r      <= {AW{1'b0}};
      rem_r     <= {(WIDTH+1){1'b0}};
      quo_r     <= ZERO;
      div_r     <= ZERO;
      cnt_r     <= {CW{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            rd_r      <= rd_in;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_r_r   <= a_neg_s;
            sel_rem_r <= op[1];
            quo_r     <= a_mag_s;
            rem_r     <= {(WIDTH+1){1'b0}};
            div_r     <= b_mag_s;
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b1;
            if (div_zero_s || overflow_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= special_s;
              rd_out_r <= rd_in;
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == LAST) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= sel_rem_r ? r_fix_s : q_fix_s;
              rd_out_r <= rd_r;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign rd_out = rd_out_r;

endmodule
